mult_arbiter: RTL

Round-robin arbiter and sequencer that shares one 64-bit iterative `mult` unit between NUM_REQ requesters. It drives the multiplier's start/operand interface, tracks the completion handshake, and returns each product to the requester that issued it. It sits between the functional-unit issue ports and a single `mult` instance, so the ports here connect directly to `mult`'s `start/mcand/mplier/product/done`.

---
 rtl/mult_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one iterative 64-bit multiplier among NUM_REQ requesters.
// Handshake: req[i] is held with its operands until gnt[i] pulses; gnt/resp_valid are one-cycle pulses.
module mult_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [64*NUM_REQ-1:0]   req_mcand,
    input  logic [64*NUM_REQ-1:0]   req_mplier,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [NUM_REQ-1:0]      resp_valid,
    output logic [63:0]             resp_product,
    output logic                    resp_error,
    output logic                    busy,
    output logic                    mult_start,
    output logic [63:0]             mult_mcand,
    output logic [63:0]             mult_mplier,
    input  logic [63:0]             mult_product,
    input  logic                    mult_done,
    output logic [1:0]              dbg_state
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t         state;
    logic [IW-1:0]  ptr;
    logic [IW-1:0]  id;
    logic           armed;
    logic [15:0]    cnt;
    logic [IW-1:0]  win;
    logic           found;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IW'(s);
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] i);
        onehot = '0;
        onehot[i] = 1'b1;
    endfunction

    // First requester at or after ptr wins, so the last winner has lowest priority.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[wrap_add(ptr, k)]) begin
                found = 1'b1;
                win   = wrap_add(ptr, k);
            end
        end
    end

    assign dbg_state = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            ptr          <= '0;
            id           <= '0;
            armed        <= 1'b0;
            cnt          <= '0;
            gnt          <= '0;
            resp_valid   <= '0;
            resp_product <= '0;
            resp_error   <= 1'b0;
            busy         <= 1'b0;
            mult_start   <= 1'b0;
            mult_mcand   <= '0;
            mult_mplier  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        id          <= win;
                        mult_mcand  <= req_mcand[win*64 +: 64];
                        mult_mplier <= req_mplier[win*64 +: 64];
                        mult_start  <= 1'b1;
                        gnt         <= onehot(win);
                        busy        <= 1'b1;
                        state       <= START;
                    end
                end
                START: begin
                    mult_start <= 1'b0;
                    gnt        <= '0;
                    armed      <= 1'b0;
                    cnt        <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    // A done level left over from the previous op only counts once it has been seen low.
                    if (!mult_done) armed <= 1'b1;
                    if (armed && mult_done) begin
                        resp_product <= mult_product;
                        resp_error   <= 1'b0;
                        resp_valid   <= onehot(id);
                        state        <= RESP;
                    end else if (cnt == 16'(TIMEOUT - 1)) begin
                        resp_product <= '0;
                        resp_error   <= 1'b1;
                        resp_valid   <= onehot(id);
                        state        <= RESP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RESP: begin
                    resp_valid <= '0;
                    ptr        <= wrap_add(id, 1);
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
